// File: rtl/pipeline_perf_monitor.sv
//------------------------------------------------------------------------------
// Module   : pipeline_perf_monitor
// Purpose  : Cycle/retire/stall/flush counters, register watch channels and
//            end-of-program detection for the 5-stage pipeline.
//            Optional macro PERF_SNAPSHOT_EN adds snapshot shadow registers.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipeline_perf_monitor #(
    parameter int CNT_W      = 32,
    parameter int NUM_WATCH  = 2,
    parameter int REG_AW     = 5,
    parameter int DATA_W     = 32,
    parameter int PC_W       = 5,
    parameter int IDLE_LIMIT = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        clear,
    input  logic                        stall,
    input  logic                        flush,
    input  logic                        retire_valid,
    input  logic                        wb_we,
    input  logic [REG_AW-1:0]           wb_rd,
    input  logic [DATA_W-1:0]           wb_data,
    input  logic [PC_W-1:0]             pc_wb,
    input  logic [NUM_WATCH*REG_AW-1:0] watch_addr,
    input  logic                        snapshot,
    input  logic [3:0]                  rd_sel,
    output logic [CNT_W-1:0]            rd_data,
    output logic [NUM_WATCH-1:0]        watch_hit,
    output logic [NUM_WATCH*DATA_W-1:0] watch_value,
    output logic                        done,
    output logic                        overflow
);

    localparam int SPC_W   = $clog2(IDLE_LIMIT + 1);
    localparam int NUM_CNT = 5;

    localparam logic [1:0]       S_IDLE  = 2'd0;
    localparam logic [1:0]       S_RUN   = 2'd1;
    localparam logic [1:0]       S_DONE  = 2'd2;
    localparam logic [CNT_W-1:0] C_MAX   = '1;
    localparam logic [SPC_W-1:0] C_LIMIT = SPC_W'(IDLE_LIMIT);

    logic [1:0]           r_state;
    logic [CNT_W-1:0]     r_cnt [NUM_CNT];
    logic [NUM_CNT-1:0]   w_inc;
    logic [NUM_CNT-1:0]   w_sat;
    logic                 w_run;
    logic [NUM_WATCH-1:0] w_hit;
    logic [NUM_WATCH-1:0] r_watch_hit;
    logic [DATA_W-1:0]    r_watch_value [NUM_WATCH];
    logic [SPC_W-1:0]     r_same_pc_cnt;
    logic [SPC_W-1:0]     w_spc_inc;
    logic                 w_same_pc;
    logic                 w_reach_limit;
    logic [PC_W-1:0]      r_last_pc;
    logic                 r_done;
    logic                 r_overflow;
    logic [CNT_W-1:0]     w_shadow_sel;
    logic [CNT_W-1:0]     w_rd_mux;
    logic [CNT_W-1:0]     r_rd_data;

    assign w_run = (r_state == S_RUN);

    // Watch channels: live in IDLE and RUN, writes to x0 never match
    generate
        for (genvar i = 0; i < NUM_WATCH; i++) begin : g_watch
            assign w_hit[i] = (r_state != S_DONE) & wb_we & retire_valid &
                              (wb_rd == watch_addr[i*REG_AW +: REG_AW]) &
                              (wb_rd != '0);
            assign watch_value[i*DATA_W +: DATA_W] = r_watch_value[i];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_watch_value[i] <= '0;
                end else if (clear) begin
                    r_watch_value[i] <= '0;
                end else if (w_hit[i]) begin
                    r_watch_value[i] <= wb_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_watch_hit <= '0;
        end else if (clear) begin
            r_watch_hit <= '0;
        end else begin
            r_watch_hit <= w_hit;
        end
    end

    // Counter order: cycles, retired, stalls, flushes, watched writes
    assign w_inc = {|w_hit, flush, stall, retire_valid, 1'b1} & {NUM_CNT{w_run}};

    generate
        for (genvar c = 0; c < NUM_CNT; c++) begin : g_cnt
            assign w_sat[c] = (r_cnt[c] == C_MAX);

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_cnt[c] <= '0;
                end else if (clear) begin
                    r_cnt[c] <= '0;
                end else if (w_inc[c] && !w_sat[c]) begin
                    r_cnt[c] <= r_cnt[c] + 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_overflow <= 1'b0;
        end else if (|(w_inc & w_sat)) begin
            r_overflow <= 1'b1;
        end
    end

    // End-of-program: the WB PC repeating IDLE_LIMIT times in a row
    assign w_same_pc     = (pc_wb == r_last_pc);
    assign w_spc_inc     = r_same_pc_cnt + 1'b1;
    assign w_reach_limit = w_run & retire_valid & w_same_pc & (w_spc_inc == C_LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_same_pc_cnt <= '0;
            r_last_pc     <= '0;
        end else if (clear) begin
            r_same_pc_cnt <= '0;
            r_last_pc     <= '0;
        end else if (w_run && retire_valid) begin
            r_same_pc_cnt <= w_same_pc ? w_spc_inc : '0;
            r_last_pc     <= pc_wb;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else if (clear) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_reach_limit) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef PERF_SNAPSHOT_EN
    logic [CNT_W-1:0] r_shadow [4];

    // Shadows take the pre-increment counter values on the snapshot edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) r_shadow[k] <= '0;
        end else if (clear) begin
            for (int k = 0; k < 4; k++) r_shadow[k] <= '0;
        end else if (w_run && snapshot) begin
            for (int k = 0; k < 4; k++) r_shadow[k] <= r_cnt[k];
        end
    end

    assign w_shadow_sel = r_shadow[rd_sel[1:0]];
`else
    logic w_snapshot_unused;
    assign w_snapshot_unused = snapshot;
    assign w_shadow_sel      = '0;
`endif

    always_comb begin
        w_rd_mux = '0;
        case (rd_sel)
            4'd0:    w_rd_mux = r_cnt[0];
            4'd1:    w_rd_mux = r_cnt[1];
            4'd2:    w_rd_mux = r_cnt[2];
            4'd3:    w_rd_mux = r_cnt[3];
            4'd4:    w_rd_mux = r_cnt[4];
            4'd5:    w_rd_mux = CNT_W'(r_same_pc_cnt);
            4'd6:    w_rd_mux = CNT_W'({r_overflow, r_done, r_state});
            4'd8,
            4'd9,
            4'd10,
            4'd11:   w_rd_mux = w_shadow_sel;
            default: w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_mux;
        end
    end

    assign rd_data   = r_rd_data;
    assign watch_hit = r_watch_hit;
    assign done      = r_done;
    assign overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_perf_monitor.sv
//------------------------------------------------------------------------------
// Module   : tb_pipeline_perf_monitor
// Purpose  : Directed self-checking bench for pipeline_perf_monitor.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipeline_perf_monitor;

    logic        clk;
    logic        reset;
    logic        enable, clear, stall, flush, retire_valid, wb_we, snapshot;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  pc_wb;
    logic [9:0]  watch_addr;
    logic [3:0]  rd_sel;
    logic [31:0] rd_data;
    logic [1:0]  watch_hit;
    logic [63:0] watch_value;
    logic        done, overflow;

    logic        enable4, clear4;
    logic [3:0]  rd_sel4;
    logic [3:0]  rd_data4;
    logic [1:0]  watch_hit4;
    logic [63:0] watch_value4;
    logic        done4, overflow4;

    int total = 0;
    int bad   = 0;

    pipeline_perf_monitor dut (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear),
        .stall(stall), .flush(flush), .retire_valid(retire_valid),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .pc_wb(pc_wb),
        .watch_addr(watch_addr), .snapshot(snapshot), .rd_sel(rd_sel),
        .rd_data(rd_data), .watch_hit(watch_hit), .watch_value(watch_value),
        .done(done), .overflow(overflow)
    );

    pipeline_perf_monitor #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .enable(enable4), .clear(clear4),
        .stall(1'b0), .flush(1'b0), .retire_valid(1'b0),
        .wb_we(1'b0), .wb_rd(5'd0), .wb_data(32'd0), .pc_wb(5'd0),
        .watch_addr(10'd0), .snapshot(1'b0), .rd_sel(rd_sel4),
        .rd_data(rd_data4), .watch_hit(watch_hit4), .watch_value(watch_value4),
        .done(done4), .overflow(overflow4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        stall = 0; flush = 0; retire_valid = 0; wb_we = 0; snapshot = 0;
        enable = 0; clear = 1;
        step(1);
        clear = 0; enable = 1;
        step(1);
    endtask

    task automatic test_reset();
        reset = 1; enable = 0; clear = 0; stall = 0; flush = 0;
        retire_valid = 0; wb_we = 0; wb_rd = 0; wb_data = 0; pc_wb = 0;
        watch_addr = 0; snapshot = 0; rd_sel = 0;
        enable4 = 0; clear4 = 0; rd_sel4 = 0;
        step(3);
        reset = 0;
        step(1);
        total++; if (rd_data !== 32'd0)     begin bad++; $display("FAIL reset_rd_data got=%0h exp=0", rd_data); end
        total++; if (watch_hit !== 2'b00)   begin bad++; $display("FAIL reset_watch_hit got=%b exp=00", watch_hit); end
        total++; if (watch_value !== 64'd0) begin bad++; $display("FAIL reset_watch_value got=%0h exp=0", watch_value); end
        total++; if (done !== 1'b0)         begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (overflow !== 1'b0)     begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    endtask

    task automatic test_cycles();
        start_run();
        rd_sel = 4'd0;
        step(11);
        total++; if (rd_data !== 32'd10) begin bad++; $display("FAIL cycles_10 got=%0d exp=10", rd_data); end
        rd_sel = 4'd6;
        step(1);
        total++; if (rd_data !== 32'd1) begin bad++; $display("FAIL status_run got=%0h exp=1", rd_data); end
    endtask

    task automatic test_stall_flush();
        start_run();
        stall = 1; flush = 1;
        step(3);
        stall = 0; flush = 0;
        rd_sel = 4'd2; step(1);
        total++; if (rd_data !== 32'd3) begin bad++; $display("FAIL stalls got=%0d exp=3", rd_data); end
        rd_sel = 4'd3; step(1);
        total++; if (rd_data !== 32'd3) begin bad++; $display("FAIL flushes got=%0d exp=3", rd_data); end
        rd_sel = 4'd0; step(1);
        total++; if (rd_data !== 32'd5) begin bad++; $display("FAIL cycles_sf got=%0d exp=5", rd_data); end
    endtask

    task automatic test_watch();
        start_run();
        watch_addr = {5'd8, 5'd8};
        retire_valid = 1; wb_we = 1; wb_rd = 5'd8; wb_data = 32'hDEADBEEF; pc_wb = 5'd1;
        step(1);
        retire_valid = 0; wb_we = 0;
        total++; if (watch_hit !== 2'b11) begin bad++; $display("FAIL watch_both_hit got=%b exp=11", watch_hit); end
        total++; if (watch_value !== {32'hDEADBEEF, 32'hDEADBEEF})
            begin bad++; $display("FAIL watch_both_value got=%0h exp=deadbeefdeadbeef", watch_value); end
        step(1);
        total++; if (watch_hit !== 2'b00) begin bad++; $display("FAIL watch_pulse got=%b exp=00", watch_hit); end
        watch_addr = 10'd0;
        retire_valid = 1; wb_we = 1; wb_rd = 5'd0; wb_data = 32'h1234; pc_wb = 5'd2;
        step(1);
        retire_valid = 0; wb_we = 0;
        total++; if (watch_hit !== 2'b00) begin bad++; $display("FAIL watch_x0 got=%b exp=00", watch_hit); end
        watch_addr = {5'd3, 5'd8};
        retire_valid = 1; wb_we = 1; wb_rd = 5'd3; wb_data = 32'h55; pc_wb = 5'd3;
        step(1);
        retire_valid = 0; wb_we = 0;
        total++; if (watch_hit !== 2'b10) begin bad++; $display("FAIL watch_single got=%b exp=10", watch_hit); end
        total++; if (watch_value !== {32'h55, 32'hDEADBEEF})
            begin bad++; $display("FAIL watch_single_value got=%0h exp=00000055deadbeef", watch_value); end
        rd_sel = 4'd4; step(1);
        total++; if (rd_data !== 32'd2) begin bad++; $display("FAIL wwrites got=%0d exp=2", rd_data); end
        rd_sel = 4'd1; step(1);
        total++; if (rd_data !== 32'd3) begin bad++; $display("FAIL retired got=%0d exp=3", rd_data); end
        // IDLE still watches
        enable = 0; clear = 1; step(1); clear = 0;
        watch_addr = {5'd8, 5'd8};
        retire_valid = 1; wb_we = 1; wb_rd = 5'd8; wb_data = 32'h0BADF00D;
        step(1);
        retire_valid = 0; wb_we = 0;
        total++; if (watch_hit !== 2'b11) begin bad++; $display("FAIL watch_idle got=%b exp=11", watch_hit); end
    endtask

    task automatic test_done();
        start_run();
        retire_valid = 1; wb_we = 0; pc_wb = 5'd5;
        step(1);
        step(7);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL done_early got=%b exp=0", done); end
        step(1);
        retire_valid = 0;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL done_set got=%b exp=1", done); end
        rd_sel = 4'd6; step(1);
        total++; if (rd_data !== 32'h6) begin bad++; $display("FAIL status_done got=%0h exp=6", rd_data); end
        rd_sel = 4'd0; step(3);
        total++; if (rd_data !== 32'd9) begin bad++; $display("FAIL cycles_frozen got=%0d exp=9", rd_data); end
        rd_sel = 4'd5; step(1);
        total++; if (rd_data !== 32'd8) begin bad++; $display("FAIL same_pc_cnt got=%0d exp=8", rd_data); end
        retire_valid = 1; wb_we = 1; wb_rd = 5'd8; wb_data = 32'h77;
        step(1);
        retire_valid = 0; wb_we = 0;
        total++; if (watch_hit !== 2'b00) begin bad++; $display("FAIL watch_in_done got=%b exp=00", watch_hit); end
        enable = 0; clear = 1; step(1); clear = 0;
        rd_sel = 4'd6; step(1);
        total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL status_clear got=%0h exp=0", rd_data); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL done_clear got=%b exp=0", done); end
    endtask

    task automatic test_saturate();
        enable4 = 1;
        step(1);
        step(20);
        rd_sel4 = 4'd0; step(1);
        total++; if (rd_data4 !== 4'd15) begin bad++; $display("FAIL sat_cycles got=%0d exp=15", rd_data4); end
        total++; if (overflow4 !== 1'b1) begin bad++; $display("FAIL sat_overflow got=%b exp=1", overflow4); end
        rd_sel4 = 4'd6; step(1);
        total++; if (rd_data4 !== 4'h9) begin bad++; $display("FAIL sat_status got=%0h exp=9", rd_data4); end
    endtask

    task automatic test_snapshot();
        logic [31:0] exp_shadow;
`ifdef PERF_SNAPSHOT_EN
        exp_shadow = 32'd6;
`else
        exp_shadow = 32'd0;
`endif
        start_run();
        step(6);
        snapshot = 1; step(1); snapshot = 0;
        rd_sel = 4'd0; step(3);
        step(1);
        total++; if (rd_data !== 32'd10) begin bad++; $display("FAIL snap_cycles got=%0d exp=10", rd_data); end
        rd_sel = 4'd8; step(1);
        total++; if (rd_data !== exp_shadow) begin bad++; $display("FAIL snap_shadow got=%0d exp=%0d", rd_data, exp_shadow); end
    endtask

    initial begin
        test_reset();
        test_cycles();
        test_stall_flush();
        test_watch();
        test_done();
        test_saturate();
        test_snapshot();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
